// File: rtl/prod_accum_pkg.sv
// Shared types and width constants for the product accumulator.
package prod_accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int IN_W_DFLT    = 64;
  localparam int GUARD_W_DFLT = 8;
  localparam int ACC_W        = IN_W_DFLT + GUARD_W_DFLT;

  function automatic int acc_width(input int in_w, input int guard_w);
    return in_w + guard_w;
  endfunction

endpackage

// File: rtl/prod_accum_accum_ctrl.sv
// Sequencing for the accumulator: IDLE/ACC/DONE FSM plus the remaining-term counter.
module accum_ctrl
  import prod_accum_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             busy,
  output logic             acc_clr,
  output logic             acc_en
);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] remaining;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      remaining <= '0;
    end else if (acc_clr) begin
      remaining <= len;
    end else if (acc_en) begin
      remaining <= remaining - LEN_W'(1);
    end
  end

  // start is only looked at in IDLE, so pulses in ACC/DONE fall through untouched
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_clr   = 1'b1;
          state_nxt = (len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_en = 1'b1;
          if (remaining == LEN_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/prod_accum.sv
// Sums a burst of unsigned products into a guarded accumulator with a sticky carry flag.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int IN_W    = IN_W_DFLT,
  parameter int GUARD_W = ACC_W - IN_W_DFLT,
  parameter int LEN_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    in_valid,
  input  logic [IN_W-1:0]         product,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IN_W+GUARD_W-1:0] sum,
  output logic                    ovf,
  output logic                    busy
);

  localparam int AW = acc_width(IN_W, GUARD_W);

  logic [AW-1:0] acc;
  logic [AW:0]   acc_sum_p0;
  logic          acc_clr;
  logic          acc_en;

  // One extra bit on top catches the carry out of the accumulator MSB
  function automatic logic [AW:0] add_carry(input logic [AW-1:0] a, input logic [IN_W-1:0] p);
    return {1'b0, a} + (AW+1)'(p);
  endfunction

  accum_ctrl #(
    .LEN_W(LEN_W)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .busy     (busy),
    .acc_clr  (acc_clr),
    .acc_en   (acc_en)
  );

  // ---- stage p0: add ----
  assign acc_sum_p0 = add_carry(acc, product);

  // ---- stage p1: accumulator register ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (acc_clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (acc_en) begin
      acc <= acc_sum_p0[AW-1:0];
      if (acc_sum_p0[AW]) begin
        ovf <= 1'b1;
      end
    end
  end

  assign sum = acc;

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench: a default (72-bit) and a GUARD_W=0 (64-bit) instance share all stimulus.
module tb_prod_accum;

  typedef struct packed {
    logic [71:0] s;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        in_valid = 1'b0;
  logic [63:0] product = '0;
  logic        out_ready = 1'b0;

  logic        in_ready72, out_valid72, ovf72, busy72;
  logic [71:0] sum72;
  logic        in_ready64, out_valid64, ovf64, busy64;
  logic [63:0] sum64;

  int checks = 0;
  int failures = 0;

  exp_t        q72[$];
  exp_t        q64[$];
  logic [63:0] tq[$];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  prod_accum u72 (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid),
    .product(product), .in_ready(in_ready72), .out_valid(out_valid72),
    .out_ready(out_ready), .sum(sum72), .ovf(ovf72), .busy(busy72)
  );

  prod_accum #(.IN_W(64), .GUARD_W(0), .LEN_W(16)) u64 (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid),
    .product(product), .in_ready(in_ready64), .out_valid(out_valid64),
    .out_ready(out_ready), .sum(sum64), .ovf(ovf64), .busy(busy64)
  );

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: the true (unbounded) total, wrapped to the accumulator width.
  function automatic exp_t model(input logic [127:0] total, input int w);
    exp_t e;
    logic [127:0] mask;
    mask = (128'd1 << w) - 128'd1;
    e.s  = 72'(total & mask);
    e.o  = ((total >> w) != 128'd0);
    return e;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 72-bit instance
  initial begin
    logic [72:0] hold;
    bit held;
    exp_t e;
    held = 0;
    hold = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 || !out_valid72) begin
        held = 0;
      end else begin
        if (held) check("stable72", {sum72, ovf72}, hold);
        if (out_ready) begin
          held = 0;
          if (q72.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected72 actual=%h required=none", sum72);
          end else begin
            e = q72.pop_front();
            check("sum72", sum72, e.s);
            check("ovf72", 72'(ovf72), 72'(e.o));
          end
        end else begin
          held = 1;
          hold = {sum72, ovf72};
        end
      end
    end
  end

  // Monitor for the GUARD_W=0 instance
  initial begin
    logic [72:0] hold;
    bit held;
    exp_t e;
    held = 0;
    hold = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 || !out_valid64) begin
        held = 0;
      end else begin
        if (held) check("stable64", {8'h00, sum64, ovf64}, hold);
        if (out_ready) begin
          held = 0;
          if (q64.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected64 actual=%h required=none", sum64);
          end else begin
            e = q64.pop_front();
            check("sum64", 72'(sum64), e.s);
            check("ovf64", 72'(ovf64), 72'(e.o));
          end
        end else begin
          held = 1;
          hold = {8'h00, sum64, ovf64};
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 72'({out_valid72, out_valid64}), 72'(0));
    check({tag, "_in_ready"}, 72'({in_ready72, in_ready64}), 72'(0));
    check({tag, "_busy"}, 72'({busy72, busy64}), 72'(0));
  endtask

  // Runs one complete transaction using the terms in tq.
  task automatic run_txn(input int gap_lo, input int gap_hi, input int dly, input bit pulses);
    logic [127:0] total;
    int n;
    total = '0;
    n = tq.size();
    foreach (tq[i]) total += 128'(tq[i]);
    q72.push_back(model(total, 72));
    q64.push_back(model(total, 64));
    start = 1'b1;
    len = 16'(n);
    tick();
    start = 1'b0;
    check("busy_after_start", 72'({busy72, busy64}), 72'(2'b11));
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_hi, gap_lo)) begin
        in_valid = 1'b0;
        product = rnd64();
        start = pulses & $urandom_range(1, 0);
        tick();
      end
      in_valid = 1'b1;
      product = tq[i];
      start = pulses & $urandom_range(1, 0);
      tick();
      in_valid = 1'b0;
      start = 1'b0;
    end
    check("latency_out_valid", 72'({out_valid72, out_valid64}), 72'(2'b11));
    check("done_in_ready", 72'({in_ready72, in_ready64}), 72'(0));
    repeat (dly) begin
      in_valid = $urandom_range(1, 0);
      product = rnd64();
      start = pulses & $urandom_range(1, 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    start = pulses;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    check_idle("after_handshake");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    check("reset_sum", sum72, 72'(0));
    reset = 1'b1;
    tick();

    tq = '{64'd5, 64'd7, 64'd11};
    run_txn(0, 0, 0, 0);
    tq = '{ONES, ONES};
    run_txn(0, 0, 1, 0);
    tq = '{ONES, 64'd1};
    run_txn(0, 0, 0, 0);
    tq = '{rnd64(), rnd64(), rnd64(), rnd64()};
    run_txn(3, 3, 5, 1);
    tq.delete();
    run_txn(0, 0, 2, 0);

    // Abort mid-ACC after 2 of 5 terms
    start = 1'b1;
    len = 16'd5;
    tick();
    start = 1'b0;
    repeat (2) begin
      in_valid = 1'b1;
      product = ONES;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    check_idle("mid_acc_reset");
    check("mid_acc_reset_sum", {sum72[70:0], ovf72}, 72'(0));
    check("mid_acc_reset_sum64", {7'd0, sum64, ovf64}, 72'(0));
    reset = 1'b1;
    tick();
    tq = '{64'd9};
    run_txn(0, 1, 1, 0);

    for (int t = 0; t < 25; t++) begin
      tq.delete();
      repeat ($urandom_range(6, 0)) tq.push_back(($urandom_range(3, 0) == 0) ? ONES : rnd64());
      run_txn(0, 2, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    repeat (3) tick();
    check("q72_drained", 72'(q72.size()), 72'(0));
    check("q64_drained", 72'(q64.size()), 72'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
